// File: rtl/read_port_source.sv
// rtl/read_port_source.sv - producer-side FIFO endpoint for a core read port
// Buffers producer words and presents the head word with a registered Full flag.
module read_port_source #(
  parameter int WORD_WIDTH  = 36,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   read_rden,
  output logic [WORD_WIDTH-1:0]  read_data_IO,
  output logic                   read_EF,
  output logic [COUNT_WIDTH-1:0] fill_count,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(DEPTH);

  logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic                   read_ef_q, read_ef_d;
  logic                   underflow_q, underflow_d;
  logic                   push, pop;

  // Handshake qualifiers use only the registered flags, so no input reaches an output.
  assign push = in_valid & in_ready_q;
  assign pop  = read_rden & read_ef_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (read_rden && !read_ef_q) underflow_d = 1'b1;
    count_d    = count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
    in_ready_d = (count_d != FULL_CNT);
    read_ef_d  = (count_d != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      read_ef_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      read_ef_q   <= read_ef_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale words stay hidden behind read_EF = 0.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign read_data_IO = mem_q[rd_ptr_q];
  assign read_EF      = read_ef_q;
  assign in_ready     = in_ready_q;
  assign fill_count   = count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_read_port_source.sv
// tb/tb_read_port_source.sv - randomized and directed bench for read_port_source
module tb_read_port_source;
  localparam int W     = 36;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          read_rden = 1'b0;
  logic [W-1:0]  read_data_IO;
  logic          read_EF;
  logic [CW-1:0] fill_count;
  logic          underflow;

  read_port_source #(.WORD_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .read_rden(read_rden), .read_data_IO(read_data_IO),
    .read_EF(read_EF), .fill_count(fill_count), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Reference model: a plain queue plus the two flags that outlive it.
  logic [W-1:0] mq[$];
  bit           m_ready = 1'b0;
  bit           m_under = 1'b0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic model_edge();
    bit do_push, do_pop;
    do_push = in_valid && m_ready;
    do_pop  = read_rden && (mq.size() != 0);
    if (read_rden && mq.size() == 0) m_under = 1'b1;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(in_data);
    m_ready = (mq.size() != DEPTH);
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    read_rden = r;
    @(posedge clock);
    if (reset_n) model_edge();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_in_ready", W'(in_ready), '0);
      chk("rst_read_EF", W'(read_EF), '0);
      chk("rst_fill", W'(fill_count), '0);
      chk("rst_underflow", W'(underflow), '0);
    end else begin
      chk("in_ready", W'(in_ready), W'(m_ready));
      chk("read_EF", W'(read_EF), W'(mq.size() != 0));
      chk("fill_count", W'(fill_count), W'(mq.size()));
      chk("underflow", W'(underflow), W'(m_under));
      if (mq.size() != 0) chk("read_data", read_data_IO, mq[0]);
    end
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("pre_edge_in_ready", W'(in_ready), '0);
    cycle(0, '0, 0);
    chk("post_release_in_ready", W'(in_ready), 1);
    chk("post_release_EF", W'(read_EF), 0);

    cycle(1, 36'h123456789, 0);
    chk("single_data", read_data_IO, 36'h123456789);
    chk("single_EF", W'(read_EF), 1);
    chk("single_fill", W'(fill_count), 1);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    chk("single_pop_EF", W'(read_EF), 0);
    chk("single_pop_fill", W'(fill_count), 0);

    for (int i = 1; i <= 4; i++) cycle(1, W'(i), 0);
    chk("full_in_ready", W'(in_ready), 0);
    chk("full_fill", W'(fill_count), 4);
    cycle(1, 36'h5, 0);
    chk("full_reject_fill", W'(fill_count), 4);
    cycle(1, 36'h5, 1);
    chk("full_pop_fill", W'(fill_count), 3);
    chk("full_pop_ready", W'(in_ready), 1);
    cycle(1, 36'h5, 0);
    chk("full_accept5_fill", W'(fill_count), 4);
    chk("full_head2", read_data_IO, 36'h2);
    for (int i = 2; i <= 5; i++) begin
      chk("full_pop_seq", read_data_IO, W'(i));
      cycle(0, '0, 1);
    end
    chk("full_drained_EF", W'(read_EF), 0);

    cycle(1, 36'h10, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, W'(36'h11 + i), 1);
      chk("stream_fill", W'(fill_count), 1);
      chk("stream_data", read_data_IO, W'(36'h11 + i));
    end
    cycle(0, '0, 1);

    cycle(1, 36'hABC, 1);
    chk("uf_flag", W'(underflow), 1);
    chk("uf_EF", W'(read_EF), 1);
    chk("uf_data", read_data_IO, 36'hABC);
    cycle(0, '0, 1);
    chk("uf_sticky", W'(underflow), 1);

    for (int i = 0; i < 3; i++) cycle(1, W'(36'hF00 + i), 0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_EF", W'(read_EF), 0);
    chk("async_fill", W'(fill_count), 0);
    chk("async_ready", W'(in_ready), 0);
    chk("async_underflow", W'(underflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(0, '0, 0);
    chk("after_rst_EF", W'(read_EF), 0);
    cycle(0, '0, 1);
    chk("after_rst_uf", W'(underflow), 1);

    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), {4'($urandom), 32'($urandom)},
            bit'($urandom_range(0, 3) != 0 ? $urandom_range(0, 1) : 1));
    end

    in_valid  = 1'b0;
    read_rden = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/read_port_source.md
# read_port_source

Device-side endpoint of an Octavo I/O read port. It accepts words from an external producer over a valid/ready handshake and buffers them in a small FIFO. It presents the head word and a Full flag to the core's read port, and pops the head when the core performs the read. It is the producer end of the read-port Empty/Full protocol: read_EF high means FULL, i.e. the core may read.

## Interface

Parameters:
- WORD_WIDTH, 36, width of each data word.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- COUNT_WIDTH, clog2(DEPTH)+1, width of fill_count.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WORD_WIDTH  producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  buffer can accept a word this cycle.
- read_rden  in  1  core read-enable for this port; one pulse pops one word.
- read_data_IO  out  WORD_WIDTH  head-of-FIFO word, presented to the core.
- read_EF  out  1  1 = FULL, a word is available; 0 = EMPTY.
- fill_count  out  COUNT_WIDTH  number of words held.
- underflow  out  1  sticky error flag: read_rden seen while read_EF = 0.

## Operation

- Storage: a DEPTH x WORD_WIDTH register array with write pointer wr_ptr, read pointer rd_ptr (clog2(DEPTH) bits, natural wrap) and a count.
- Push when in_valid & in_ready at the edge: write mem[wr_ptr] and increment wr_ptr.
- Pop when read_rden & read_EF at the edge: increment rd_ptr.
- Count update: count_next = count + push - pop.
- Simultaneous push and pop (count between 1 and DEPTH-1): both take effect and the count is unchanged. Order is preserved: the popped word is the old head.
- Full (count == DEPTH): in_ready = 0 and no push is accepted. A pop in the same cycle does not enable a push that cycle; in_ready rises on the following cycle.
- Empty (count == 0): read_rden is an underflow. underflow sets to 1; pointers and data are untouched. A push in that same cycle is still accepted.
- underflow stays at 1 until reset.
- read_data_IO = mem[rd_ptr]. It is driven from state registers only, with no combinational path from in_* or read_rden. When read_EF = 0 its value is don't-care, but it must be stable.
- All outputs are registered functions of count_next: read_EF = (count != 0), in_ready = (count != DEPTH), fill_count = count.
- Reset (asserted at any time, including mid-transfer) asynchronously clears:
  - pointers and count to 0
  - read_EF to 0, underflow to 0, fill_count to 0
  - in_ready to 0
- Buffered words are discarded on reset; memory contents need not be cleared.
- After reset release, in_ready goes to 1 at the first rising edge; read_EF stays 0.

## Timing

- Push-to-visible latency: 1 cycle. A word accepted at edge N drives read_EF = 1 and read_data_IO = that word after edge N, if the FIFO was empty.
- Pop latency: 1 cycle. After a popping edge, read_data_IO shows the next word and read_EF reflects the new count.
- The core samples read_EF through its own registered EF selector. This block must never show read_EF = 1 without valid data behind it in the same cycle.
- Throughput: one push and one pop per cycle sustained.
- in_ready depends only on registered state; the producer may hold in_valid high indefinitely.
- No combinational input-to-output paths anywhere.

## Test plan

- Reset then idle: hold reset_n low 3 cycles, release. Required: in_ready 0 during reset, 1 one edge after release; read_EF = 0; fill_count = 0; underflow = 0.
- Single word: push 0x123456789 at edge N. Required: after N, read_EF = 1, read_data_IO = 0x123456789, fill_count = 1. Pulse read_rden at N+2. Required: after N+2, read_EF = 0, fill_count = 0.
- Fill to full: push 0x1, 0x2, 0x3, 0x4 back to back. Required: in_ready = 0 and fill_count = 4 after the 4th push; a 5th word 0x5 held with in_valid is not accepted. Pop once. Required: in_ready returns to 1 one cycle later; 0x5 is then accepted; the pop sequence reads 0x1, 0x2, 0x3, 0x4, 0x5.
- Streaming: in_valid and read_rden held high for 20 cycles with one word preloaded; producer sends an incrementing 0x10, 0x11, .... Required: fill_count stays at 1; the data read is strictly sequential; pointers wrap past DEPTH with no loss.
- Underflow: read_rden while empty, together with a push of 0xABC. Required: underflow = 1 (sticky); 0xABC is accepted; read_EF = 1 next cycle; a further reset clears underflow.
- Reset mid-operation: 3 words buffered, reset_n asserted asynchronously between edges. Required: read_EF, fill_count and in_ready drop immediately; after release, read_EF = 0 and old data is never presented.
